// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared state, opcode-class, ALU and fault encodings for the multi-cycle controller.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_ALU_R,
        C_ALU_I,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_HALT,
        C_ILLEGAL
    } op_class_e;

    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQZ = 4'h7;
    localparam logic [3:0] OP_HALT = 4'h8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic [1:0]       alu_op;
    logic             alu_src_imm;
    logic             reg_we;
    logic             wb_sel;
    logic             halted;
    logic [1:0]       fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, opcode, zero, mem_ack,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_op, alu_src_imm,
               reg_we, wb_sel, halted, fault, retired
    );

    modport slave (
        output run, opcode, zero, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_op, alu_src_imm,
               reg_we, wb_sel, halted, fault, retired
    );
endinterface

// File: rtl/multicycle_ctrl_opdecode.sv
// ctrl_opdecode: maps a 4-bit opcode onto its instruction class.
module ctrl_opdecode
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] op_i,
    output op_class_e  cls_o
);
    always_comb begin
        cls_o = op_i[3] ? (op_i == OP_HALT ? C_HALT : C_ILLEGAL) :
                !op_i[2] ? C_ALU_R :
                op_i == OP_ADDI ? C_ALU_I :
                op_i == OP_LW   ? C_LOAD  :
                op_i == OP_SW   ? C_STORE : C_BRANCH;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/mem/writeback sequencer with memory req/ack arbitration,
// timeout and illegal-opcode faults, and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_ctrl_if.master   bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [1:0]        fault_q, fault_d;
    logic              retire, mem_phase, timeout;
    logic [3:0]        dec_op;
    op_class_e         cls;

    // In DECODE the class must come from the live opcode, since op_q is only being loaded then.
    assign dec_op = state_q == S_DECODE ? bus.opcode : op_q;

    ctrl_opdecode u_dec (
        .op_i  (dec_op),
        .cls_o (cls)
    );

    assign mem_phase = state_q == S_FETCH || state_q == S_MEM;
    assign timeout   = MEM_TIMEOUT != 0 && mem_phase && !bus.mem_ack &&
                       wait_q == WAIT_W'(MEM_TIMEOUT - 1);
    assign wait_d    = mem_phase && !bus.mem_ack && !timeout ? wait_q + 1'b1 : '0;
    assign ret_d     = ret_q + CNT_W'(retire);

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        fault_d         = fault_q;
        retire          = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.addr_sel    = 1'b0;
        bus.ir_we       = 1'b0;
        bus.pc_we       = 1'b0;
        bus.pc_src      = 1'b0;
        bus.alu_op      = ALU_ADD;
        bus.alu_src_imm = 1'b0;
        bus.reg_we      = 1'b0;
        bus.wb_sel      = 1'b0;
        bus.halted      = state_q == S_HALT;
        bus.fault       = fault_q;
        bus.retired     = ret_q;
        case (state_q)
            S_IDLE: state_d = bus.run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_we   = bus.mem_ack;
                bus.pc_we   = bus.mem_ack;
                state_d     = bus.mem_ack ? S_DECODE : timeout ? S_HALT : S_FETCH;
                fault_d     = timeout ? F_TIMEOUT : fault_q;
            end
            S_DECODE: begin
                op_d    = bus.opcode;
                state_d = cls == C_HALT || cls == C_ILLEGAL ? S_HALT : S_EXEC;
                retire  = cls == C_HALT;
                fault_d = cls == C_ILLEGAL ? F_ILLEGAL : fault_q;
            end
            S_EXEC: begin
                bus.alu_op      = cls == C_ALU_R ? op_q[1:0] : cls == C_BRANCH ? ALU_SUB : ALU_ADD;
                bus.alu_src_imm = cls == C_ALU_I || cls == C_LOAD || cls == C_STORE;
                bus.pc_we       = cls == C_BRANCH && bus.zero;
                bus.pc_src      = cls == C_BRANCH && bus.zero;
                state_d         = cls == C_BRANCH ? S_FETCH :
                                  cls == C_LOAD || cls == C_STORE ? S_MEM : S_WB;
                retire          = cls == C_BRANCH;
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = cls == C_STORE;
                state_d      = bus.mem_ack ? (cls == C_STORE ? S_FETCH : S_WB) :
                               timeout ? S_HALT : S_MEM;
                retire       = bus.mem_ack && cls == C_STORE;
                fault_d      = timeout ? F_TIMEOUT : fault_q;
            end
            S_WB: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = cls == C_LOAD;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            ret_q   <= '0;
            fault_q <= F_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
            fault_q <= fault_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors; stimulus queues the expected output bundle,
// a negedge monitor pops and compares it.
module tb_multicycle_ctrl;
    localparam logic [13:0] REQ   = 14'h2000;
    localparam logic [13:0] WE    = 14'h1000;
    localparam logic [13:0] AS    = 14'h0800;
    localparam logic [13:0] IRW   = 14'h0400;
    localparam logic [13:0] PCW   = 14'h0200;
    localparam logic [13:0] PCS   = 14'h0100;
    localparam logic [13:0] A_SUB = 14'h0040;
    localparam logic [13:0] A_OR  = 14'h00C0;
    localparam logic [13:0] IMM   = 14'h0020;
    localparam logic [13:0] RW    = 14'h0010;
    localparam logic [13:0] WBS   = 14'h0008;
    localparam logic [13:0] HLT   = 14'h0004;
    localparam logic [13:0] F_ILL = 14'h0001;
    localparam logic [13:0] F_TO  = 14'h0002;
    localparam logic [13:0] FTCH  = REQ | IRW | PCW;

    typedef struct {
        logic [29:0] v;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t e;

    multicycle_ctrl_if #(.CNT_W(16)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] actual();
        return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.pc_we, bus.pc_src,
                bus.alu_op, bus.alu_src_imm, bus.reg_we, bus.wb_sel, bus.halted, bus.fault,
                bus.retired};
    endfunction

    task automatic check(input logic [29:0] act, input logic [29:0] exp, input string nm);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got ctl=%h ret=%0d, want ctl=%h ret=%0d",
                     nm, act[29:16], act[15:0], exp[29:16], exp[15:0]);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(actual(), e.v, e.nm);
        end
    end

    task automatic step(input logic r, input logic [3:0] op, input logic z, input logic ack,
                        input logic [13:0] s, input logic [15:0] ret, input string nm);
        @(posedge clk);
        #1;
        bus.run = r;
        bus.opcode = op;
        bus.zero = z;
        bus.mem_ack = ack;
        sb.push_back('{v: {s, ret}, nm: nm});
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.mem_ack = 1'b0;
        sb.push_back('{v: '0, nm: "reset_low"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back('{v: '0, nm: "reset_release"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run = 1'b0;
        bus.opcode = 4'h0;
        bus.zero = 1'b0;
        bus.mem_ack = 1'b0;
        reset_pulse();
        for (int i = 0; i < 5; i++) step(0, 4'h0, 0, 1, 14'h0, 0, "idle_hold");
        step(1, 4'h0, 0, 0, 14'h0, 0, "run_sampled");
        // ADD; opcode bus is scrambled after DECODE to prove op_q is used
        step(0, 4'h0, 0, 1, FTCH, 0, "add_fetch");
        step(0, 4'h0, 0, 0, 14'h0, 0, "add_decode");
        step(0, 4'hF, 0, 0, 14'h0, 0, "add_exec");
        step(0, 4'hF, 0, 0, RW, 0, "add_wb");
        step(0, 4'h5, 0, 1, FTCH, 1, "lw_fetch");
        step(0, 4'h5, 0, 0, 14'h0, 1, "lw_decode");
        step(0, 4'hF, 0, 0, IMM, 1, "lw_exec");
        for (int i = 0; i < 3; i++) step(0, 4'hF, 0, 0, REQ | AS, 1, "lw_mem_wait");
        step(0, 4'hF, 0, 1, REQ | AS, 1, "lw_mem_ack");
        step(0, 4'hF, 0, 0, RW | WBS, 1, "lw_wb");
        step(0, 4'h6, 0, 1, FTCH, 2, "sw_fetch");
        step(0, 4'h6, 0, 0, 14'h0, 2, "sw_decode");
        step(0, 4'h0, 0, 0, IMM, 2, "sw_exec");
        step(0, 4'h0, 0, 1, REQ | WE | AS, 2, "sw_mem");
        step(0, 4'h7, 0, 1, FTCH, 3, "beqz1_fetch");
        step(0, 4'h7, 0, 0, 14'h0, 3, "beqz1_decode");
        step(0, 4'h7, 1, 0, A_SUB | PCW | PCS, 3, "beqz_taken");
        step(0, 4'h7, 0, 1, FTCH, 4, "beqz0_fetch");
        step(0, 4'h7, 0, 0, 14'h0, 4, "beqz0_decode");
        step(0, 4'h7, 0, 0, A_SUB, 4, "beqz_not_taken");
        step(0, 4'h3, 0, 0, REQ, 5, "or_fetch_wait");
        step(0, 4'h3, 0, 1, FTCH, 5, "or_fetch");
        step(0, 4'h3, 0, 0, 14'h0, 5, "or_decode");
        step(0, 4'h0, 0, 0, A_OR, 5, "or_exec");
        step(0, 4'h0, 0, 0, RW, 5, "or_wb");
        step(0, 4'h4, 0, 1, FTCH, 6, "addi_fetch");
        step(0, 4'h4, 0, 0, 14'h0, 6, "addi_decode");
        step(0, 4'h0, 0, 0, IMM, 6, "addi_exec");
        step(0, 4'h0, 0, 0, RW, 6, "addi_wb");
        step(0, 4'hA, 0, 1, FTCH, 7, "ill_fetch");
        step(0, 4'hA, 0, 0, 14'h0, 7, "ill_decode");
        step(1, 4'h0, 1, 1, HLT | F_ILL, 7, "ill_halt");
        step(1, 4'h0, 1, 1, HLT | F_ILL, 7, "ill_halt_sticky");

        reset_pulse();
        step(1, 4'h0, 0, 0, 14'h0, 0, "run_b");
        for (int i = 0; i < 14; i++) step(0, 4'h5, 0, 0, REQ, 0, "fetch_slow");
        step(0, 4'h5, 0, 1, FTCH, 0, "fetch_ack_last");
        step(0, 4'h5, 0, 0, 14'h0, 0, "lw2_decode");
        step(0, 4'h5, 0, 0, IMM, 0, "lw2_exec");
        step(0, 4'h5, 0, 0, REQ | AS, 0, "lw2_mem_wait");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check(actual(), '0, "async_reset");
        sb.push_back('{v: '0, nm: "async_reset_held"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back('{v: '0, nm: "async_release"});
        step(1, 4'h0, 0, 0, 14'h0, 0, "run_c");
        step(0, 4'h8, 0, 1, FTCH, 0, "halt_fetch");
        step(0, 4'h8, 0, 0, 14'h0, 0, "halt_decode");
        step(1, 4'h0, 0, 1, HLT, 1, "halt_state");
        step(1, 4'h0, 0, 1, HLT, 1, "halt_sticky");

        reset_pulse();
        step(1, 4'h0, 0, 0, 14'h0, 0, "run_d");
        for (int i = 0; i < 15; i++) step(0, 4'h0, 0, 0, REQ, 0, "fetch_no_ack");
        step(0, 4'h0, 0, 1, HLT | F_TO, 0, "timeout_halt");
        step(0, 4'h0, 0, 1, HLT | F_TO, 0, "timeout_sticky");

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
